lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store controller directly upstream of data_memory. It drives data_memory's A, WriteData and WE ports and consumes its ReadData.
- Converts RV32I load/store requests (LB/LH/LW/LBU/LHU, SB/SH/SW) into word-only memory accesses.
- Sub-word stores use a read-modify-write sequence.
- Loads are lane-extracted and sign/zero-extended.
- Returns a single-cycle response pulse.

Parameters:
ADDR_W, 32, width of req_addr and mem_A
DATA_W, 32, data width; only 32 supported

Ports:
clk  in  1  rising-edge clock, shared with data_memory
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (size/sign)
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-aligned
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  extended load data (0 for stores and errors)
rsp_err  out  1  valid with rsp_valid: illegal funct3 or misaligned access
mem_A  out  ADDR_W  word-aligned address to data_memory A
mem_WriteData  out  DATA_W  to data_memory WriteData
mem_WE  out  1  to data_memory WE
mem_ReadData  in  DATA_W  from data_memory ReadData (combinational read)

Behaviour:
- One clock (clk). Reset is synchronous, active-low (rst_n).
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_WE=0, mem_A=0, mem_WriteData=0, all capture registers 0.
- States: IDLE, LD, ST_RD, ST_WR, RSP.
- req_ready = (state==IDLE).
- Accept edge: latch we, funct3, addr, wdata. Next state:
  - error -> RSP with err=1
  - load -> LD
  - SW -> ST_WR
  - SB/SH -> ST_RD
- Legal load funct3: 0 (LB), 1 (LH), 2 (LW), 4 (LBU), 5 (LHU). Legal store funct3: 0 (SB), 1 (SH), 2 (SW). Any other value is an error.
- Misaligned access is an error:
  - halfword: addr[0]=1
  - word: addr[1:0]!=0
- An errored request never asserts mem_WE.
- mem_A = {addr[ADDR_W-1:2],2'b00} in LD/ST_RD/ST_WR; holds its last value elsewhere.
- LD: on the edge, capture mem_ReadData >> (8*addr[1:0]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Then go to RSP.
- ST_RD: latch mem_ReadData as old word, then go to ST_WR.
- ST_WR:
  - mem_WE = rst_n (a reset asserted in this cycle suppresses the write).
  - mem_WriteData = old word with the selected byte lane(s) replaced by req_wdata[7:0] or [15:0]; for SW it is req_wdata.
  - Memory writes on this edge; then go to RSP.
- RSP: rsp_valid=1 for exactly one cycle, then IDLE. No response backpressure.
- Latency from accept edge to rsp_valid: load 2 cycles, SW 2, SB/SH 3, error 1.
- mem_WE is 0 in every state except ST_WR.
- req fields are ignored while req_ready=0.
- Reset mid-operation: abort to IDLE, no response, no partial write.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: misaligned accesses raise rsp_err as described under Behaviour, with no memory access.
- Undefined: misalignment is never an error.
  - The address low bits below the access size are forced to zero (halfword: addr[0]=0; word: addr[1:0]=0).
  - The access proceeds normally.
  - Illegal funct3 still errors.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> req_ready=1, rsp_valid=0, mem_WE=0, rsp_rdata=0.
- SW addr 0x10, wdata 0xDEADBEEF, then LW 0x10 -> mem_WE pulses once with mem_A=0x10; load gives rsp_rdata=0xDEADBEEF 2 cycles after accept.
- Memory word 0x10 = 0xDEADBEEF:
  - LB 0x13 -> 0xFFFFFFDE
  - LBU 0x13 -> 0x000000DE
  - LH 0x12 -> 0xFFFFDEAD
  - LHU 0x10 -> 0x0000BEEF
- Memory word 0x10 = 0xDEADBEEF, SB 0x11 wdata 0x55 -> ST_RD then ST_WR; mem_WriteData=0xDEAD55EF; rsp_valid 3 cycles after accept; a following LW reads 0xDEAD55EF.
- Error cases:
  - LW 0x12 with LSU_MISALIGN_TRAP_EN defined -> rsp_err=1 one cycle after accept; mem_WE never asserted.
  - Same request with the macro undefined -> reads word 0x10, rsp_err=0.
  - funct3=3 load -> rsp_err=1.
- SH 0x20 accepted; rst_n=0 during ST_WR -> mem_WE=0 that cycle; memory at 0x20 unchanged; no rsp_valid; state IDLE.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and data_memory bus between an RV32I load/store unit and lsu_mem_ctrl.
// master = requester + memory side, slave = the controller.
interface lsu_mem_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic [ADDR_W-1:0] mem_A;
   logic [DATA_W-1:0] mem_WriteData;
   logic              mem_WE;
   logic [DATA_W-1:0] mem_ReadData;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ReadData,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_A, mem_WriteData, mem_WE
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ReadData,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_A, mem_WriteData, mem_WE
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store to word-only data_memory: lane extract/extend for loads, RMW for SB/SH.
// LSU_MISALIGN_TRAP_EN: misaligned accesses error out instead of being forced aligned.
module lsu_mem_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   lsu_mem_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LD, ST_RD, ST_WR, RSP} state_t;

   state_t      state;
   logic [2:0]  funct3;
   logic [1:0]  addrLo;
   logic [15:0] wdata;

   logic              legal, reqErr;
   logic [ADDR_W-1:0] reqAddrEff;
   logic [4:0]        sh;
   logic [DATA_W-1:0] rdShift, ldData, laneMask, merged;

   always_comb begin
      legal      = bus.req_we ? (bus.req_funct3 inside {3'd0, 3'd1, 3'd2})
                              : (bus.req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      reqAddrEff = bus.req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
      reqErr = !legal ||
               (bus.req_funct3[1:0] == 2'd1 && bus.req_addr[0]) ||
               (bus.req_funct3[1:0] == 2'd2 && bus.req_addr[1:0] != 2'b00);
`else
      reqErr = !legal;
      // drop the address bits below the access size rather than trapping
      if (bus.req_funct3[1:0] == 2'd1)      reqAddrEff[0]   = 1'b0;
      else if (bus.req_funct3[1:0] == 2'd2) reqAddrEff[1:0] = 2'b00;
`endif
   end

   always_comb begin
      sh      = {addrLo, 3'b000};
      rdShift = bus.mem_ReadData >> sh;
      case (funct3)
         3'd0:    ldData = {{(DATA_W-8){rdShift[7]}}, rdShift[7:0]};
         3'd1:    ldData = {{(DATA_W-16){rdShift[15]}}, rdShift[15:0]};
         3'd4:    ldData = {{(DATA_W-8){1'b0}}, rdShift[7:0]};
         3'd5:    ldData = {{(DATA_W-16){1'b0}}, rdShift[15:0]};
         default: ldData = rdShift;
      endcase
      laneMask = (funct3[0] ? DATA_W'(16'hFFFF) : DATA_W'(8'hFF)) << sh;
      merged   = (bus.mem_ReadData & ~laneMask) | ((DATA_W'(wdata) << sh) & laneMask);
   end

   assign bus.req_ready = (state == IDLE);
   // a reset landing in the write cycle must kill the write on that same edge
   assign bus.mem_WE    = (state == ST_WR) && rst_n;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state             <= IDLE;
         funct3            <= '0;
         addrLo            <= '0;
         wdata             <= '0;
         bus.rsp_valid     <= 1'b0;
         bus.rsp_rdata     <= '0;
         bus.rsp_err       <= 1'b0;
         bus.mem_A         <= '0;
         bus.mem_WriteData <= '0;
      end else begin
         bus.rsp_valid <= 1'b0;
         case (state)
            IDLE: if (bus.req_valid) begin
               funct3 <= bus.req_funct3;
               addrLo <= reqAddrEff[1:0];
               wdata  <= bus.req_wdata[15:0];
               if (reqErr) begin
                  state         <= RSP;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_rdata <= '0;
               end else begin
                  bus.rsp_err <= 1'b0;
                  bus.mem_A   <= {reqAddrEff[ADDR_W-1:2], 2'b00};
                  if (!bus.req_we) state <= LD;
                  else if (bus.req_funct3[1:0] == 2'd2) begin
                     state             <= ST_WR;
                     bus.mem_WriteData <= bus.req_wdata;
                  end else state <= ST_RD;
               end
            end
            LD: begin
               bus.rsp_rdata <= ldData;
               bus.rsp_valid <= 1'b1;
               state         <= RSP;
            end
            ST_RD: begin
               bus.mem_WriteData <= merged;
               state             <= ST_WR;
            end
            ST_WR: begin
               bus.rsp_rdata <= '0;
               bus.rsp_valid <= 1'b1;
               state         <= RSP;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed vector bench for lsu_mem_ctrl against a small word-addressed data_memory model.
module tb_lsu_mem_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lsu_mem_ctrl_if bus ();
   lsu_mem_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic [31:0] mem [0:63];
   assign bus.mem_ReadData = mem[bus.mem_A[7:2]];
   always @(posedge clk) if (bus.mem_WE) mem[bus.mem_A[7:2]] <= bus.mem_WriteData;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] expRd;
      logic        expErr;
      int          expLat;
      int          expWe;
      logic [31:0] expWd;
      logic [31:0] expA;
   } vec_t;

   int checks = 0;
   int failures = 0;
   vec_t vecs [0:18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expRd, input logic expErr,
                               input int expLat, input int expWe, input logic [31:0] expWd,
                               input logic [31:0] expA);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.expRd = expRd;
      v.expErr = expErr; v.expLat = expLat; v.expWe = expWe; v.expWd = expWd; v.expA = expA;
      return v;
   endfunction

   task automatic runVec(input string tag, input vec_t v);
      int lat = 0;
      int weCnt = 0;
      bit got = 1'b0;
      logic [31:0] wA = '0;
      logic [31:0] wD = '0;
      @(negedge clk);
      chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1; bus.req_we = v.we; bus.req_funct3 = v.f3;
      bus.req_addr = v.addr; bus.req_wdata = v.wdata;
      @(posedge clk); #1;
      bus.req_valid = 1'b0; bus.req_wdata = 32'hFFFF_FFFF;
      while (!got && lat < 8) begin
         lat++;
         if (bus.mem_WE) begin weCnt++; wA = bus.mem_A; wD = bus.mem_WriteData; end
         if (bus.rsp_valid) got = 1'b1;
         else begin @(posedge clk); #1; end
      end
      chk({tag, ".latency"}, 32'(got ? lat : -1), 32'(v.expLat));
      chk({tag, ".rdata"}, bus.rsp_rdata, v.expRd);
      chk({tag, ".err"}, 32'(bus.rsp_err), 32'(v.expErr));
      chk({tag, ".weCount"}, 32'(weCnt), 32'(v.expWe));
      if (v.expWe != 0) begin
         chk({tag, ".wdata"}, wD, v.expWd);
         chk({tag, ".memA"}, wA, v.expA);
      end
      @(posedge clk); #1;
      chk({tag, ".pulseEnd"}, 32'(bus.rsp_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] w20;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
      bus.req_addr = '0; bus.req_wdata = '0;

      vecs[0]  = mk(1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 1, 32'hDEADBEEF, 32'h10);
      vecs[1]  = mk(0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 0, 32'h0, 32'h0);
      vecs[2]  = mk(0, 3'd0, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 2, 0, 32'h0, 32'h0);
      vecs[3]  = mk(0, 3'd4, 32'h13, 32'h0,        32'h000000DE, 0, 2, 0, 32'h0, 32'h0);
      vecs[4]  = mk(0, 3'd1, 32'h12, 32'h0,        32'hFFFFDEAD, 0, 2, 0, 32'h0, 32'h0);
      vecs[5]  = mk(0, 3'd5, 32'h10, 32'h0,        32'h0000BEEF, 0, 2, 0, 32'h0, 32'h0);
      vecs[6]  = mk(1, 3'd0, 32'h11, 32'hAAAABB55, 32'h0,        0, 3, 1, 32'hDEAD55EF, 32'h10);
      vecs[7]  = mk(0, 3'd2, 32'h10, 32'h0,        32'hDEAD55EF, 0, 2, 0, 32'h0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      vecs[8]  = mk(0, 3'd2, 32'h12, 32'h0,        32'h0,        1, 1, 0, 32'h0, 32'h0);
`else
      vecs[8]  = mk(0, 3'd2, 32'h12, 32'h0,        32'hDEAD55EF, 0, 2, 0, 32'h0, 32'h0);
`endif
      vecs[9]  = mk(0, 3'd3, 32'h10, 32'h0,        32'h0,        1, 1, 0, 32'h0, 32'h0);
      vecs[10] = mk(1, 3'd4, 32'h10, 32'h0,        32'h0,        1, 1, 0, 32'h0, 32'h0);
      vecs[11] = mk(1, 3'd2, 32'h20, 32'h0,        32'h0,        0, 2, 1, 32'h0, 32'h20);
      vecs[12] = mk(1, 3'd1, 32'h22, 32'h1234ABCD, 32'h0,        0, 3, 1, 32'hABCD0000, 32'h20);
      vecs[13] = mk(0, 3'd5, 32'h22, 32'h0,        32'h0000ABCD, 0, 2, 0, 32'h0, 32'h0);
      vecs[14] = mk(0, 3'd1, 32'h22, 32'h0,        32'hFFFFABCD, 0, 2, 0, 32'h0, 32'h0);
      vecs[15] = mk(0, 3'd0, 32'h23, 32'h0,        32'hFFFFFFAB, 0, 2, 0, 32'h0, 32'h0);
      vecs[16] = mk(0, 3'd2, 32'h20, 32'h0,        32'hABCD0000, 0, 2, 0, 32'h0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      vecs[17] = mk(1, 3'd1, 32'h21, 32'h00009999, 32'h0,        1, 1, 0, 32'h0, 32'h0);
      w20 = 32'hABCD0000;
`else
      vecs[17] = mk(1, 3'd1, 32'h21, 32'h00009999, 32'h0,        0, 3, 1, 32'hABCD9999, 32'h20);
      w20 = 32'hABCD9999;
`endif
      vecs[18] = mk(0, 3'd2, 32'h20, 32'h0,        w20,          0, 2, 0, 32'h0, 32'h0);

      repeat (2) @(posedge clk);
      #1;
      chk("reset.ready", 32'(bus.req_ready), 32'd1);
      chk("reset.rspValid", 32'(bus.rsp_valid), 32'd0);
      chk("reset.memWE", 32'(bus.mem_WE), 32'd0);
      chk("reset.rdata", bus.rsp_rdata, 32'd0);
      chk("reset.memA", bus.mem_A, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 19; i++) runVec($sformatf("v%0d", i), vecs[i]);

      // SH aborted by reset in its write cycle
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd1;
      bus.req_addr = 32'h20; bus.req_wdata = 32'h7777;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      chk("abort.weBefore", 32'(bus.mem_WE), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort.weSuppressed", 32'(bus.mem_WE), 32'd0);
      @(posedge clk); #1;
      chk("abort.ready", 32'(bus.req_ready), 32'd1);
      chk("abort.rspValid", 32'(bus.rsp_valid), 32'd0);
      rst_n = 1'b1;
      begin
         int seen = 0;
         for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid || bus.mem_WE) seen++;
         end
         chk("abort.quiet", 32'(seen), 32'd0);
      end
      runVec("abort.readback", vecs[18]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
